// File: rtl/cordic_pkg.sv
// Shared constants, state encoding and helpers for the iterative CORDIC engine.
package cordic_pkg;

    localparam int ANGLE_W = 18;
    localparam logic signed [ANGLE_W-1:0] HALF_PI = 18'sd65536;
    localparam logic signed [ANGLE_W-1:0] VAL_MIN = 18'sh20000;
    localparam logic signed [ANGLE_W-1:0] VAL_MAX = 18'sh1ffff;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_t;

    // round(atan(2^-i) * 2^17 / pi)
    localparam logic signed [ANGLE_W-1:0] ATAN_TABLE [16] = '{
        18'sd32768, 18'sd19344, 18'sd10221, 18'sd5188,
        18'sd2604,  18'sd1303,  18'sd652,   18'sd326,
        18'sd163,   18'sd81,    18'sd41,    18'sd20,
        18'sd10,    18'sd5,     18'sd3,     18'sd1
    };

    // Two's-complement negation that clamps the most negative value.
    function automatic logic signed [ANGLE_W-1:0] sat_neg(input logic signed [ANGLE_W-1:0] v);
        if (v == VAL_MIN) begin
            sat_neg = VAL_MAX;
        end else begin
            sat_neg = -v;
        end
    endfunction

endpackage

// File: rtl/cordic_atan_rom.sv
// Arctangent constant lookup for the CORDIC micro-rotation index.
module cordic_atan_rom
    import cordic_pkg::*;
(
    input  logic [3:0]                idx,
    output logic signed [ANGLE_W-1:0] atan
);

    // Pure table read; the table is a package constant.
    always_comb begin
        atan = ATAN_TABLE[idx];
    end

endmodule

// File: rtl/cordic_stage.sv
// Single rotation-mode CORDIC micro-rotation; direction follows the sign of z.
module cordic_stage
    import cordic_pkg::*;
(
    input  logic signed [ANGLE_W-1:0] x,
    input  logic signed [ANGLE_W-1:0] y,
    input  logic signed [ANGLE_W-1:0] z,
    input  logic [3:0]                stage,
    input  logic signed [ANGLE_W-1:0] atan,
    output logic signed [ANGLE_W-1:0] x_next,
    output logic signed [ANGLE_W-1:0] y_next,
    output logic signed [ANGLE_W-1:0] z_next
);

    logic signed [ANGLE_W-1:0] x_shift_s;
    logic signed [ANGLE_W-1:0] y_shift_s;

    // Shift-and-add rotation, 18-bit wrap throughout.
    always_comb begin
        x_shift_s = x >>> stage;
        y_shift_s = y >>> stage;
        if (z[ANGLE_W-1] == 1'b0) begin
            x_next = x - y_shift_s;
            y_next = y + x_shift_s;
            z_next = z - atan;
        end else begin
            x_next = x + y_shift_s;
            y_next = y - x_shift_s;
            z_next = z + atan;
        end
    end

endmodule

// File: rtl/cordic_sequencer.sv
// Iterative rotation-mode CORDIC: quadrant pre-rotation on accept, then ITERS
// micro-rotations through one shared stage, then a one-cycle done pulse.
module cordic_sequencer
    import cordic_pkg::*;
#(
    parameter int ITERS = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic signed [ANGLE_W-1:0] x_in,
    input  logic signed [ANGLE_W-1:0] y_in,
    input  logic signed [ANGLE_W-1:0] z_in,
    output logic                      busy,
    output logic                      done,
    output logic signed [ANGLE_W-1:0] x_out,
    output logic signed [ANGLE_W-1:0] y_out,
    output logic signed [ANGLE_W-1:0] z_out
);

    localparam logic [3:0] CNT_LAST = 4'(ITERS - 1);

    state_t                    state_r;
    logic [3:0]                cnt_r;
    logic                      busy_r;
    logic                      done_r;
    logic signed [ANGLE_W-1:0] x_r;
    logic signed [ANGLE_W-1:0] y_r;
    logic signed [ANGLE_W-1:0] z_r;

    logic signed [ANGLE_W-1:0] x_pre_s;
    logic signed [ANGLE_W-1:0] y_pre_s;
    logic signed [ANGLE_W-1:0] z_pre_s;
    logic signed [ANGLE_W-1:0] atan_s;
    logic signed [ANGLE_W-1:0] x_nx_s;
    logic signed [ANGLE_W-1:0] y_nx_s;
    logic signed [ANGLE_W-1:0] z_nx_s;

    cordic_atan_rom u_rom (
        .idx  (cnt_r),
        .atan (atan_s)
    );

    cordic_stage u_stage (
        .x      (x_r),
        .y      (y_r),
        .z      (z_r),
        .stage  (cnt_r),
        .atan   (atan_s),
        .x_next (x_nx_s),
        .y_next (y_nx_s),
        .z_next (z_nx_s)
    );

    // Fold angles beyond +/-pi/2 back into the convergence range by a quarter turn.
    always_comb begin
        case (z_in[ANGLE_W-1:ANGLE_W-2])
            2'b01: begin
                x_pre_s = sat_neg(y_in);
                y_pre_s = x_in;
                z_pre_s = z_in - HALF_PI;
            end
            2'b10: begin
                x_pre_s = y_in;
                y_pre_s = sat_neg(x_in);
                z_pre_s = z_in + HALF_PI;
            end
            default: begin
                x_pre_s = x_in;
                y_pre_s = y_in;
                z_pre_s = z_in;
            end
        endcase
    end

    // Sequencer FSM, iteration counter and working registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
            cnt_r   <= 4'd0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            x_r     <= 18'sd0;
            y_r     <= 18'sd0;
            z_r     <= 18'sd0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE, DONE: begin
                    if (start) begin
                        state_r <= ITER;
                        cnt_r   <= 4'd0;
                        busy_r  <= 1'b1;
                        x_r     <= x_pre_s;
                        y_r     <= y_pre_s;
                        z_r     <= z_pre_s;
                    end else begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                ITER: begin
                    x_r   <= x_nx_s;
                    y_r   <= y_nx_s;
                    z_r   <= z_nx_s;
                    cnt_r <= cnt_r + 4'd1;
                    if (cnt_r == CNT_LAST) begin
                        state_r <= DONE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end else begin
                        state_r <= ITER;
                        busy_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign busy  = busy_r;
    assign done  = done_r;
    assign x_out = x_r;
    assign y_out = y_r;
    assign z_out = z_r;

endmodule

// File: tb/tb_cordic_sequencer.sv
// Scoreboard bench for cordic_sequencer: expected results from an integer
// CORDIC reference plus a trigonometric sanity bound, checked on each done.
module tb_cordic_sequencer;

    localparam int ITERS = 16;

    logic clk = 1'b0;
    logic rst_n;
    logic start;
    logic signed [17:0] x_in, y_in, z_in;
    logic signed [17:0] x_out, y_out, z_out;
    logic busy, done;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    typedef struct {
        int  ex;
        int  ey;
        int  ez;
        int  cyc;
        real ix;
        real iy;
        int  tol;
    } exp_t;

    exp_t q[$];

    cordic_sequencer #(.ITERS(ITERS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .x_in  (x_in),
        .y_in  (y_in),
        .z_in  (z_in),
        .busy  (busy),
        .done  (done),
        .x_out (x_out),
        .y_out (y_out),
        .z_out (z_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int wrap18(input int v);
        logic signed [17:0] t;
        t = 18'(v);
        return int'(t);
    endfunction

    function automatic int neg_sat(input int v);
        return (v == -131072) ? 131071 : -v;
    endfunction

    // Reference: quarter-turn fold, then ITERS shift-add rotations; plus ideal K*R(theta)*v.
    function automatic exp_t predict(input int xi, input int yi, input int zi, input int tol);
        exp_t e;
        int   atan_t[16];
        int   x, y, z, xn, yn;
        real  k, p, th;
        atan_t = '{32768, 19344, 10221, 5188, 2604, 1303, 652, 326,
                   163, 81, 41, 20, 10, 5, 3, 1};
        if (zi >= 65536) begin
            x = neg_sat(yi); y = xi; z = zi - 65536;
        end else if (zi < -65536) begin
            x = yi; y = neg_sat(xi); z = zi + 65536;
        end else begin
            x = xi; y = yi; z = zi;
        end
        k = 1.0;
        p = 1.0;
        for (int i = 0; i < ITERS; i++) begin
            if (z >= 0) begin
                xn = x - (y >>> i); yn = y + (x >>> i); z = z - atan_t[i];
            end else begin
                xn = x + (y >>> i); yn = y - (x >>> i); z = z + atan_t[i];
            end
            x = wrap18(xn); y = wrap18(yn); z = wrap18(z);
            k = k * $sqrt(1.0 + p);
            p = p / 4.0;
        end
        th   = real'(zi) * 3.14159265358979 / 131072.0;
        e.ex = x; e.ey = y; e.ez = z;
        e.ix = k * (real'(xi) * $cos(th) - real'(yi) * $sin(th));
        e.iy = k * (real'(xi) * $sin(th) + real'(yi) * $cos(th));
        e.tol = tol;
        e.cyc = 0;
        return e;
    endfunction

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    task automatic chk_near(input string nm, input int act, input real req, input int tol);
        real d;
        checks++;
        d = real'(act) - req;
        if (d < 0.0) d = -d;
        if (d > real'(tol)) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0.1f +/- %0d", nm, act, req, tol);
        end
    endtask

    // Monitor: every done pops one expectation; overdue expectations are reported.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n) begin
            if (done) begin
                if (q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("done_cycle", cyc, e.cyc);
                    chk("busy_at_done", int'(busy), 0);
                    chk("x_exact", int'(x_out), e.ex);
                    chk("y_exact", int'(y_out), e.ey);
                    chk("z_exact", int'(z_out), e.ez);
                    chk_near("z_residual", int'(z_out), 0.0, 4);
                    if (e.tol > 0) begin
                        chk_near("x_ideal", int'(x_out), e.ix, e.tol);
                        chk_near("y_ideal", int'(y_out), e.iy, e.tol);
                    end
                end
            end else if (q.size() != 0 && cyc > q[0].cyc) begin
                chk("missed_done", cyc, q[0].cyc);
                void'(q.pop_front());
            end
        end
    end

    task automatic launch(input int xv, input int yv, input int zv, input int tol, input bit hold);
        exp_t e;
        int   n;
        n = 0;
        @(negedge clk);
        while (busy && n < 64) begin
            @(negedge clk);
            n++;
        end
        chk("launch_idle", int'(busy), 0);
        x_in  = 18'(xv);
        y_in  = 18'(yv);
        z_in  = 18'(zv);
        start = 1'b1;
        @(posedge clk);
        #1;
        e = predict(xv, yv, zv, tol);
        e.cyc = cyc + ITERS;
        q.push_back(e);
        @(negedge clk);
        if (!hold) start = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || q.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", n < 100 ? 1 : 0, 1);
    endtask

    initial begin
        exp_t e;
        int xv, yv, zv;
        rst_n = 1'b0;
        start = 1'b1;
        x_in  = 18'sd1234;
        y_in  = 18'sd567;
        z_in  = 18'sd890;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_x", int'(x_out), 0);
        chk("rst_y", int'(y_out), 0);
        chk("rst_z", int'(z_out), 0);
        start = 1'b0;
        rst_n = 1'b1;

        // Directed angles: 45 deg, 135 deg (folded), -pi (folded).
        launch(39797, 0, 32768, 16, 1'b0);
        wait_idle();
        launch(39797, 0, 98304, 16, 1'b0);
        wait_idle();
        launch(39797, 0, -131072, 16, 1'b0);
        wait_idle();
        // Saturating negation on fold; result wraps, so only the exact model applies.
        launch(0, -131072, 70000, -1, 1'b0);
        wait_idle();

        // start pulses while busy must be dropped.
        launch(20000, -15000, -40000, 64, 1'b0);
        repeat (2) @(negedge clk);
        x_in = 18'sd777; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        z_in = -18'sd9999; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();

        // start held through DONE: second accept on the DONE edge.
        launch(39797, 0, 16384, 16, 1'b1);
        x_in = 18'sd39797; y_in = 18'sd0; z_in = -18'sd50000;
        repeat (ITERS + 1) @(posedge clk);
        #1;
        e = predict(39797, 0, -50000, 16);
        e.cyc = cyc + ITERS;
        q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        wait_idle();

        // Reset on the 5th iteration edge aborts with no done.
        launch(30000, 10000, 60000, 64, 1'b0);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        q.delete();
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_x", int'(x_out), 0);
        chk("abort_y", int'(y_out), 0);
        chk("abort_z", int'(z_out), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (ITERS + 4) @(negedge clk);
        chk("abort_idle", int'(busy), 0);

        // Randomized operations with random gaps (gap 0 lands in the DONE cycle).
        for (int n = 0; n < 24; n++) begin
            xv = int'($urandom_range(60000)) - 30000;
            yv = int'($urandom_range(60000)) - 30000;
            zv = int'($urandom_range(262143)) - 131072;
            launch(xv, yv, zv, 64, 1'b0);
            repeat ($urandom_range(3)) @(negedge clk);
        end
        wait_idle();
        chk("scoreboard_empty", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
